// File: rtl/axi_lite_csr_regfile_if.sv
// AXI4-Lite CSR bus bundle between the platform wrapper and
// the accelerator register file.
interface axi_lite_csr_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                csr_AWVALID;
  logic                csr_AWREADY;
  logic [ADDR_W-1:0]   csr_AWADDR;
  logic [2:0]          csr_AWPROT;
  logic                csr_WVALID;
  logic                csr_WREADY;
  logic [DATA_W-1:0]   csr_WDATA;
  logic [DATA_W/8-1:0] csr_WSTRB;
  logic                csr_BVALID;
  logic                csr_BREADY;
  logic [1:0]          csr_BRESP;
  logic                csr_ARVALID;
  logic                csr_ARREADY;
  logic [ADDR_W-1:0]   csr_ARADDR;
  logic [2:0]          csr_ARPROT;
  logic                csr_RVALID;
  logic                csr_RREADY;
  logic [DATA_W-1:0]   csr_RDATA;
  logic [1:0]          csr_RRESP;

  modport master (
    output csr_AWVALID, csr_AWADDR, csr_AWPROT,
    input  csr_AWREADY,
    output csr_WVALID, csr_WDATA, csr_WSTRB,
    input  csr_WREADY,
    input  csr_BVALID, csr_BRESP,
    output csr_BREADY,
    output csr_ARVALID, csr_ARADDR, csr_ARPROT,
    input  csr_ARREADY,
    input  csr_RVALID, csr_RDATA, csr_RRESP,
    output csr_RREADY
  );

  modport slave (
    input  csr_AWVALID, csr_AWADDR, csr_AWPROT,
    output csr_AWREADY,
    input  csr_WVALID, csr_WDATA, csr_WSTRB,
    output csr_WREADY,
    output csr_BVALID, csr_BRESP,
    input  csr_BREADY,
    input  csr_ARVALID, csr_ARADDR, csr_ARPROT,
    output csr_ARREADY,
    output csr_RVALID, csr_RDATA, csr_RRESP,
    input  csr_RREADY
  );
endinterface

// File: rtl/axi_lite_csr_regfile.sv
// AXI4-Lite register file: RW regs driven on regs_out,
// RO regs sampled from regs_in, per-register write pulses.
module axi_lite_csr_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  axi_lite_csr_regfile_if.slave        csr,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  input  logic [NUM_REGS*DATA_W-1:0]   regs_in,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int OFS_W = $clog2(DATA_W/8);
  localparam int NB    = DATA_W/8;
  // One extra index bit so a power-of-two file still sees the
  // first address past its end as out of range.
  localparam int DEC_W = IDX_W + 1;

  typedef enum logic [1:0] {
    W_COLLECT,
    W_COMMIT,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

  w_state_t w_state, w_state_d;
  r_state_t r_state, r_state_d;

  logic awready, awready_d;
  logic wready, wready_d;
  logic aw_held, aw_held_d;
  logic w_held, w_held_d;
  logic bvalid, bvalid_d;
  logic [1:0] bresp;

  logic arready, arready_d;
  logic rvalid, rvalid_d;
  logic [DATA_W-1:0] rdata, rdata_d;
  logic [1:0] rresp, rresp_d;

  logic [DEC_W-1:0]  aw_dec;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     wstrb_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic aw_fire, w_fire, ar_fire, w_commit;
  logic w_bad, r_bad;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic [DEC_W-1:0] ar_dec;

  assign aw_fire  = csr.csr_AWVALID & awready;
  assign w_fire   = csr.csr_WVALID & wready;
  assign ar_fire  = csr.csr_ARVALID & arready;
  assign w_commit = (w_state == W_COMMIT);

  assign w_bad = aw_dec >= DEC_W'(NUM_REGS);
  assign w_idx = aw_dec[IDX_W-1:0];
  assign ar_dec = csr.csr_ARADDR[OFS_W +: DEC_W];
  assign r_bad = ar_dec >= DEC_W'(NUM_REGS);
  assign r_idx = ar_dec[IDX_W-1:0];

  assign csr.csr_AWREADY = awready;
  assign csr.csr_WREADY  = wready;
  assign csr.csr_BVALID  = bvalid;
  assign csr.csr_BRESP   = bresp;
  assign csr.csr_ARREADY = arready;
  assign csr.csr_RVALID  = rvalid;
  assign csr.csr_RDATA   = rdata;
  assign csr.csr_RRESP   = rresp;

  logic unused;
  assign unused = ^{
    csr.csr_AWPROT,
    csr.csr_ARPROT,
    csr.csr_AWADDR[OFS_W-1:0],
    csr.csr_ARADDR[OFS_W-1:0],
    csr.csr_AWADDR[ADDR_W-1:OFS_W+DEC_W],
    csr.csr_ARADDR[ADDR_W-1:OFS_W+DEC_W]
  };

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state <= W_COLLECT;
      awready <= 1'b0;
      wready  <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      w_state <= w_state_d;
      awready <= awready_d;
      wready  <= wready_d;
      aw_held <= aw_held_d;
      w_held  <= w_held_d;
      bvalid  <= bvalid_d;
    end
  end

  always_comb begin
    w_state_d = w_state;
    awready_d = awready;
    wready_d  = wready;
    aw_held_d = aw_held;
    w_held_d  = w_held;
    bvalid_d  = bvalid;
    unique case (w_state)
      W_COLLECT: begin
        if (aw_fire) aw_held_d = 1'b1;
        if (w_fire) w_held_d = 1'b1;
        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
        if (aw_held_d && w_held_d)
          w_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        bvalid_d  = 1'b1;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (csr.csr_BREADY) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_COLLECT;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aw_dec   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp    <= 2'b00;
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else begin
      wr_pulse <= '0;
      if (aw_fire)
        aw_dec <= csr.csr_AWADDR[OFS_W +: DEC_W];
      if (w_fire) begin
        wdata_q <= csr.csr_WDATA;
        wstrb_q <= csr.csr_WSTRB;
      end
      if (w_commit) begin
        bresp <= w_bad ? 2'b10 : 2'b00;
        if (!w_bad && !RO_MASK[w_idx]) begin
          wr_pulse[w_idx] <= 1'b1;
          for (int b = 0; b < NB; b++)
            if (wstrb_q[b])
              regs_q[w_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
    end else begin
      r_state <= r_state_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
    end
  end

  always_comb begin
    r_state_d = r_state;
    arready_d = arready;
    rvalid_d  = rvalid;
    unique case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_fire) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (csr.csr_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  // Register array read is pre-commit, so a same-edge write stays hidden.
  always_comb begin
    rdata_d = '0;
    rresp_d = 2'b10;
    if (!r_bad) begin
      rresp_d = 2'b00;
      if (RO_MASK[r_idx])
        rdata_d = regs_in[r_idx*DATA_W +: DATA_W];
      else
        rdata_d = regs_q[r_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      rresp <= 2'b00;
    end else if (ar_fire) begin
      rdata <= rdata_d;
      rresp <= rresp_d;
    end
  end

endmodule
